led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arb_pkg.sv | 13 +
 rtl/tick_gen.sv | 41 ++++
 rtl/led_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_led_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED bank arbiter.
//   state_e  : arbiter FSM states (IDLE = nobody owns the bank, OWN = one owner)
//   LEDS_OFF : board LED drive with every LED dark (LEDs are active-low)
package led_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam logic [7:0] LEDS_OFF = 8'hFF;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: a TICK_DIV-bit free-running counter. tick is registered and
// is high for exactly the one cycle after the counter wraps from all-ones to 0.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : synchronous active-high reset (counter = 0, tick = 0)
//   tick  : one-cycle pulse every 2^TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 21
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);

  logic [TICK_DIV-1:0] cnt_q;
  logic [TICK_DIV-1:0] cnt_d;
  logic                tick_q;
  logic                tick_d;

  // Next counter value and wrap detection.
  always_comb begin
    cnt_d  = cnt_q + TICK_DIV'(1);
    // Registering "counter is all-ones" lands the pulse in the cycle where
    // the counter reads zero after a wrap, but never right after reset.
    tick_d = &cnt_q;
  end

  // Counter and tick registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter that shares one 8-LED bank among NREQ requesters.
// An owner keeps the bank for at least HOLD_TICKS ticks unless it releases;
// once the hold time is served, any other requester preempts it.
// Ports:
//   CLK     : system clock, rising edge
//   RESET   : synchronous active-high reset
//   req     : level-sensitive request, one bit per requester
//   pattern : byte i is requester i's pattern, active-high
//   grant   : registered one-hot owner indicator, zero when idle
//   LEDS    : registered active-low LED drive (owner's pattern inverted)
//   tick    : prescaler pulse, one cycle every 2^TICK_DIV cycles
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int HOLD_TICKS = 8,
  parameter int TICK_DIV   = 21
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   pattern,
  output logic [NREQ-1:0]     grant,
  output logic [7:0]          LEDS,
  output logic                tick
);

  localparam int         IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);

  // Index following k in wrapping order.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] k);
    logic [IDXW-1:0] n;
    if (int'(k) >= NREQ - 1) begin
      n = '0;
    end else begin
      n = k + IDXW'(1);
    end
    return n;
  endfunction

  // First set bit of r at or after start, wrapping. MSB of the result is the
  // "found" flag, the low bits are the index. Scanning from the far end lets
  // the nearest candidate overwrite farther ones.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDXW-1:0] start);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDXW'((int'(start) + k) % NREQ);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_e            state_q,  state_d;
  logic [IDXW-1:0]   owner_q,  owner_d;
  logic [7:0]        hold_q,   hold_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant_q,  grant_d;
  logic [7:0]        leds_q,   leds_d;

  logic              tick_s;
  logic [NREQ-1:0]   others_s;
  logic [NREQ-1:0]   search_req_s;
  logic [IDXW-1:0]   search_start_s;
  logic [IDXW:0]     pick_s;
  logic              pick_ok_s;
  logic [IDXW-1:0]   pick_idx_s;
  logic              leave_s;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick_s)
  );

  // Candidate search shared by the idle grant, release and preemption paths.
  always_comb begin
    others_s          = req;
    others_s[owner_q] = 1'b0;
    if (state_q == IDLE) begin
      // From idle the pointer itself is eligible.
      search_req_s   = req;
      search_start_s = rr_ptr_q;
    end else begin
      // While owned the owner is excluded and the scan starts just past it.
      search_req_s   = others_s;
      search_start_s = next_idx(owner_q);
    end
    pick_s     = rr_pick(search_req_s, search_start_s);
    pick_ok_s  = pick_s[IDXW];
    pick_idx_s = pick_s[IDXW-1:0];
  end

  // Arbitration FSM: next state, owner, hold counter, pointer and outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    leds_d   = LEDS_OFF;
    leave_s  = 1'b0;

    case (state_q)
      IDLE: begin
        leds_d = LEDS_OFF;
        if (pick_ok_s) begin
          state_d  = OWN;
          owner_d  = pick_idx_s;
          hold_d   = 8'd0;
          rr_ptr_d = next_idx(pick_idx_s);
          grant_d  = NREQ'(1) << pick_idx_s;
        end else begin
          grant_d  = '0;
        end
      end

      OWN: begin
        // LEDS follow the current owner with one register of latency.
        leds_d  = ~pattern[{owner_q, 3'b000} +: 8];
        // Release, or preemption once the hold time is fully served; either
        // beats a coincident tick because the new owner starts from zero.
        leave_s = !req[owner_q] || ((hold_q == HOLD_MAX) && (|others_s));
        if (leave_s) begin
          hold_d = 8'd0;
          if (pick_ok_s) begin
            owner_d  = pick_idx_s;
            rr_ptr_d = next_idx(pick_idx_s);
            grant_d  = NREQ'(1) << pick_idx_s;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
          end
        end else if (tick_s && (hold_q < HOLD_MAX)) begin
          hold_d = hold_q + 8'd1;
        end else begin
          hold_d = hold_q;
        end
      end

      default: begin
        state_d  = IDLE;
        owner_d  = '0;
        hold_d   = 8'd0;
        rr_ptr_d = '0;
        grant_d  = '0;
        leds_d   = LEDS_OFF;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      hold_q   <= 8'd0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      leds_q   <= LEDS_OFF;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      leds_q   <= leds_d;
    end
  end

  assign grant = grant_q;
  assign LEDS  = leds_q;
  assign tick  = tick_s;

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter (NREQ=3, HOLD_TICKS=3, TICK_DIV=2).
// Stimulus is driven on the falling edge; the reference model predicts the
// outputs after the next rising edge and queues them; a monitor compares
// shortly after every rising edge.
module tb_led_arbiter;

  localparam int NREQ        = 3;
  localparam int HOLD        = 3;
  localparam int TD          = 2;
  localparam int TICK_PERIOD = 1 << TD;
  localparam int STARVE_MAX  = (NREQ - 1) * (HOLD + 1);

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [7:0]      leds;
    logic            tick;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] pattern = '0;
  logic [NREQ-1:0]   grant;
  logic [7:0]        LEDS;
  logic              tick;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: owner index (-1 = nobody), ticks held,
  // round-robin start point, cycles elapsed since the last reset edge.
  int m_owner = -1;
  int m_hold  = 0;
  int m_rr    = 0;
  int m_n     = 0;
  int wait_t[NREQ];

  led_arbiter #(
    .NREQ       (NREQ),
    .HOLD_TICKS (HOLD),
    .TICK_DIV   (TD)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .LEDS    (LEDS),
    .tick    (tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester in r at or after index start, wrapping; -1 if none.
  function automatic int first_high(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge with the given inputs and
  // queue the outputs expected just after that edge.
  task automatic model_step(input logic rst, input logic [NREQ-1:0] r,
                            input logic [8*NREQ-1:0] p);
    exp_t            e;
    int              cand;
    logic            cur_tick;
    logic [NREQ-1:0] others;
    cur_tick = (m_n > 0) && (m_n % TICK_PERIOD == 0);
    if (rst) begin
      m_owner = -1;
      m_hold  = 0;
      m_rr    = 0;
      m_n     = 0;
      e.leds  = 8'hFF;
    end else begin
      e.leds = (m_owner >= 0) ? ~p[m_owner*8 +: 8] : 8'hFF;
      if (m_owner < 0) begin
        cand = first_high(r, m_rr);
        if (cand >= 0) begin
          m_owner = cand;
          m_hold  = 0;
          m_rr    = (cand + 1) % NREQ;
        end
      end else begin
        others          = r;
        others[m_owner] = 1'b0;
        if (!r[m_owner] || (m_hold == HOLD && others != '0)) begin
          cand    = first_high(others, (m_owner + 1) % NREQ);
          m_owner = cand;
          m_hold  = 0;
          if (cand >= 0) m_rr = (cand + 1) % NREQ;
        end else if (cur_tick && m_hold < HOLD) begin
          m_hold++;
        end
      end
      m_n++;
    end
    e.grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    e.tick  = (m_n > 0) && (m_n % TICK_PERIOD == 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [NREQ-1:0] r,
                       input logic [8*NREQ-1:0] p, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      RESET   = rst;
      req     = r;
      pattern = p;
      model_step(rst, r, p);
    end
  endtask

  // Monitor: compare queued expectations and invariants after every edge.
  initial begin
    exp_t e;
    int   worst;
    for (int j = 0; j < NREQ; j++) wait_t[j] = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", int'(grant), int'(e.grant));
        check("leds",  int'(LEDS),  int'(e.leds));
        check("tick",  int'(tick),  int'(e.tick));
        check("grant_onehot0", int'($onehot0(grant)), 1);
        check("grant_to_idle", int'(grant & ~req), 0);
        worst = 0;
        for (int j = 0; j < NREQ; j++) begin
          if (RESET || !req[j] || grant[j]) wait_t[j] = 0;
          else if (tick) wait_t[j]++;
          if (wait_t[j] > worst) worst = wait_t[j];
        end
        check("starvation_bound", int'(worst <= STARVE_MAX), 1);
      end
    end
  end

  // Stimulus: directed scenarios, then a long randomized run.
  initial begin
    logic [NREQ-1:0]   r;
    logic [8*NREQ-1:0] p;
    logic              rst;
    p = {8'h3C, 8'hA5, 8'h81};

    drive(1'b1, 3'b000, p, 2);
    drive(1'b0, 3'b000, p, 20);   // idle: no grant, LEDs dark, ticks every 4
    drive(1'b0, 3'b010, p, 10);   // requester 1 alone with pattern A5
    drive(1'b0, 3'b000, p, 2);
    drive(1'b0, 3'b001, p, 2);    // requester 0 takes ownership
    drive(1'b0, 3'b011, p, 40);   // hold expiry ping-pongs between 0 and 1
    drive(1'b0, 3'b000, p, 2);
    drive(1'b0, 3'b100, p, 6);    // requester 2 owns, a tick goes by
    drive(1'b0, 3'b001, p, 4);    // owner 2 releases, 0 takes over
    drive(1'b0, 3'b000, p, 4);    // back to idle
    drive(1'b0, 3'b111, p, 12);
    drive(1'b1, 3'b111, p, 1);    // reset mid-ownership
    drive(1'b0, 3'b111, p, 8);    // arbitration restarts at requester 0
    p = {8'hFF, 8'h00, 8'h5A};
    drive(1'b0, 3'b111, p, 3);    // owner's pattern change shows up next cycle

    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < NREQ; j++) begin
        if ($urandom_range(0, 7) == 0) r[j] = ~r[j];
      end
      p   = {$urandom(), $urandom()};
      rst = ($urandom_range(0, 1999) == 0);
      drive(rst, r, p, 1);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
